// File: rtl/sent_pkg.sv
// sent_pkg: shared SENT CRC constants, mode encodings, FSM states and helpers
package sent_pkg;

    localparam logic [2:0] MODE_FAST6 = 3'b001;
    localparam logic [2:0] MODE_FAST4 = 3'b010;
    localparam logic [2:0] MODE_FAST3 = 3'b011;
    localparam logic [2:0] MODE_SHORT = 3'b100;
    localparam logic [2:0] MODE_ENH   = 3'b101;

    localparam logic [3:0] CRC4_SEED = 4'b0101;
    localparam logic [5:0] CRC6_SEED = 6'b010101;

    // x^4+x^3+x^2+1 and x^6+x^4+x^3+1, leading term implicit
    localparam logic [3:0] CRC4_POLY = 4'hD;
    localparam logic [5:0] CRC6_POLY = 6'h19;

    localparam logic [2:0] NIB_FAST6 = 3'd6;
    localparam logic [2:0] NIB_FAST4 = 3'd4;
    localparam logic [2:0] NIB_FAST3 = 3'd3;
    localparam logic [2:0] NIB_SHORT = 3'd4;
    localparam logic [2:0] NIB_ENH   = 3'd6;

    // CRC-4 state advanced by four zero bits through CRC4_POLY
    localparam logic [3:0] T4 [16] = '{4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
                                       4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5};

    typedef enum logic [2:0] {IDLE, ACCUM, AUG, WAIT_CRC, RESULT} state_e;

    // Zero marks an invalid mode
    function automatic logic [2:0] nib_count(input logic [2:0] m);
        return m == MODE_FAST6 ? NIB_FAST6 :
               m == MODE_FAST4 ? NIB_FAST4 :
               m == MODE_FAST3 ? NIB_FAST3 :
               m == MODE_SHORT ? NIB_SHORT :
               m == MODE_ENH   ? NIB_ENH   : 3'd0;
    endfunction

    function automatic logic mode_valid(input logic [2:0] m);
        return nib_count(m) != 3'd0;
    endfunction

    // One MSB-first bit step of the CRC-6 register
    function automatic logic [5:0] crc6_bit(input logic [5:0] c, input logic b);
        return {c[4:0], 1'b0} ^ ((c[5] ^ b) ? CRC6_POLY : 6'h00);
    endfunction

endpackage

// File: rtl/sent_crc_step.sv
// sent_crc_step: one-cycle nibble update for CRC-4 (table) and CRC-6 (bitwise)
module sent_crc_step
    import sent_pkg::*;
(
    input  logic       i_is6,
    input  logic       i_aug,
    input  logic [5:0] i_crc,
    input  logic [3:0] i_nib,
    output logic [5:0] o_crc
);

    logic [5:0] w_c6;
    logic [5:0] w_z6;

    // CRC-6 takes four data bits normally, six zero bits during augmentation
    always_comb begin
        w_c6 = i_crc;
        for (int k = 3; k >= 0; k--) w_c6 = crc6_bit(w_c6, i_nib[k]);
        w_z6 = i_crc;
        for (int k = 0; k < 6; k++) w_z6 = crc6_bit(w_z6, 1'b0);
        o_crc = i_is6 ? (i_aug ? w_z6 : w_c6) : {2'b00, T4[i_crc[3:0]] ^ i_nib};
    end

endmodule

// File: rtl/sent_rx_crc_check.sv
// sent_rx_crc_check: accumulates received SENT nibbles and checks the frame CRC
module sent_rx_crc_check
    import sent_pkg::*;
(
    input  logic       clk_rx,
    input  logic       reset_n_rx,
    input  logic [2:0] mode_i,
    input  logic       frame_start_i,
    input  logic       nibble_valid_i,
    input  logic [3:0] nibble_i,
    input  logic       crc_valid_i,
    input  logic [5:0] crc_i,
    output logic       crc_check_done_o,
    output logic       crc_ok_o,
    output logic       crc_err_o,
    output logic       frame_err_o,
    output logic [5:0] crc_calc_o
);

    state_e     r_state;
    logic [2:0] r_mode;
    logic [2:0] r_cnt;
    logic [5:0] r_crc;
    logic       r_ok;
    logic       r_err;
    logic       r_ferr;

    state_e     w_state_nxt;
    logic [2:0] w_mode_nxt;
    logic [2:0] w_cnt_nxt;
    logic [5:0] w_crc_nxt;
    logic       w_ok_nxt;
    logic       w_err_nxt;
    logic       w_ferr_nxt;
    logic       w_fail;

    logic       w_is6;
    logic       w_aug;
    logic [2:0] w_n;
    logic [5:0] w_step;
    logic [5:0] w_seed;
    logic       w_match;

    assign w_is6   = r_mode == MODE_ENH;
    assign w_aug   = r_state == AUG;
    assign w_n     = nib_count(r_mode);
    assign w_seed  = mode_i == MODE_ENH ? CRC6_SEED : {2'b00, CRC4_SEED};
    assign w_match = w_is6 ? crc_i == r_crc : crc_i[3:0] == r_crc[3:0];

    sent_crc_step u_step (
        .i_is6 (w_is6),
        .i_aug (w_aug),
        .i_crc (r_crc),
        .i_nib (w_aug ? 4'h0 : nibble_i),
        .o_crc (w_step)
    );

    // FSM state and frame context registers
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            r_state <= IDLE;
            r_mode  <= 3'd0;
            r_cnt   <= 3'd0;
            r_crc   <= CRC6_SEED;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_cnt   <= w_cnt_nxt;
            r_crc   <= w_crc_nxt;
            r_ok    <= w_ok_nxt;
            r_err   <= w_err_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    // Next state; frame_start_i overrides everything, including a pending result
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;
        w_crc_nxt   = r_crc;
        w_ok_nxt    = r_ok;
        w_err_nxt   = r_err;
        w_ferr_nxt  = r_ferr;
        w_fail      = 1'b0;
        case (r_state)
            ACCUM: begin
                if (nibble_valid_i && r_cnt != w_n) begin
                    w_crc_nxt = w_step;
                    w_cnt_nxt = r_cnt + 3'd1;
                end
                w_fail      = crc_valid_i;
                w_state_nxt = r_cnt == w_n ? AUG : ACCUM;
            end
            AUG: begin
                w_crc_nxt   = w_step;
                w_fail      = crc_valid_i;
                w_state_nxt = WAIT_CRC;
            end
            WAIT_CRC: begin
                w_fail = nibble_valid_i;
                if (crc_valid_i) begin
                    w_state_nxt = RESULT;
                    w_ok_nxt    = w_match;
                    w_err_nxt   = !w_match;
                    w_ferr_nxt  = 1'b0;
                end
            end
            RESULT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_fail || (frame_start_i && !mode_valid(mode_i))) begin
            w_state_nxt = RESULT;
            w_ok_nxt    = 1'b0;
            w_err_nxt   = 1'b0;
            w_ferr_nxt  = 1'b1;
        end
        if (frame_start_i && mode_valid(mode_i)) begin
            w_state_nxt = ACCUM;
            w_mode_nxt  = mode_i;
            w_cnt_nxt   = 3'd0;
            w_crc_nxt   = w_seed;
        end
    end

    // Registered result outputs, pulsed for the cycle after RESULT
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            crc_check_done_o <= 1'b0;
            crc_ok_o         <= 1'b0;
            crc_err_o        <= 1'b0;
            frame_err_o      <= 1'b0;
            crc_calc_o       <= 6'd0;
        end else begin
            crc_check_done_o <= r_state == RESULT;
            crc_ok_o         <= r_state == RESULT && r_ok;
            crc_err_o        <= r_state == RESULT && r_err;
            frame_err_o      <= r_state == RESULT && r_ferr;
            crc_calc_o       <= r_state == RESULT ? r_crc : crc_calc_o;
        end
    end

endmodule

// File: tb/tb_sent_rx_crc_check.sv
// tb_sent_rx_crc_check: directed self-checking bench for sent_rx_crc_check
module tb_sent_rx_crc_check;

    logic       clk_rx = 1'b0;
    logic       reset_n_rx = 1'b0;
    logic [2:0] mode_i = 3'd0;
    logic       frame_start_i = 1'b0;
    logic       nibble_valid_i = 1'b0;
    logic [3:0] nibble_i = 4'd0;
    logic       crc_valid_i = 1'b0;
    logic [5:0] crc_i = 6'd0;
    logic       crc_check_done_o;
    logic       crc_ok_o;
    logic       crc_err_o;
    logic       frame_err_o;
    logic [5:0] crc_calc_o;

    int tests = 0;
    int failed = 0;
    logic [5:0] w_ref;

    sent_rx_crc_check dut (
        .clk_rx           (clk_rx),
        .reset_n_rx       (reset_n_rx),
        .mode_i           (mode_i),
        .frame_start_i    (frame_start_i),
        .nibble_valid_i   (nibble_valid_i),
        .nibble_i         (nibble_i),
        .crc_valid_i      (crc_valid_i),
        .crc_i            (crc_i),
        .crc_check_done_o (crc_check_done_o),
        .crc_ok_o         (crc_ok_o),
        .crc_err_o        (crc_err_o),
        .frame_err_o      (frame_err_o),
        .crc_calc_o       (crc_calc_o)
    );

    always #5 clk_rx = ~clk_rx;

    // Bit-serial reference: seed, 24 data bits MSB first, then six zero bits
    function automatic logic [5:0] m_crc6(input logic [23:0] d);
        logic [5:0]  c;
        logic [29:0] s;
        c = 6'h15;
        s = {d, 6'b0};
        for (int i = 29; i >= 0; i--) c = {c[4:0], 1'b0} ^ ((c[5] ^ s[i]) ? 6'h19 : 6'h00);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_rx);
    endtask

    task automatic start(input logic [2:0] m);
        mode_i = m;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
    endtask

    task automatic nib(input logic [3:0] n);
        nibble_valid_i = 1'b1;
        nibble_i = n;
        tick();
        nibble_valid_i = 1'b0;
    endtask

    task automatic send_crc(input logic [5:0] c);
        crc_valid_i = 1'b1;
        crc_i = c;
        tick();
        crc_valid_i = 1'b0;
    endtask

    task automatic frame(input logic [2:0] m, input logic [23:0] d, input int n, input logic [5:0] c);
        start(m);
        for (int i = 0; i < n; i++) nib(d[23-4*i -: 4]);
        tick();
        tick();
        send_crc(c);
    endtask

    // Called right after the edge that sampled the terminating input
    task automatic result(input string tag, input logic ok, input logic err, input logic fe,
                          input logic [5:0] calc, input logic ck_calc);
        chk({tag, ".early"}, 6'(crc_check_done_o), 6'd0);
        tick();
        chk({tag, ".done"}, 6'(crc_check_done_o), 6'd1);
        chk({tag, ".flags"}, {3'b0, crc_ok_o, crc_err_o, frame_err_o}, {3'b0, ok, err, fe});
        if (ck_calc) chk({tag, ".calc"}, crc_calc_o, calc);
        tick();
        chk({tag, ".pulse"}, 6'(crc_check_done_o), 6'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst.flags", {2'b0, crc_check_done_o, crc_ok_o, crc_err_o, frame_err_o}, 6'd0);
        chk("rst.calc", crc_calc_o, 6'd0);
        reset_n_rx = 1'b1;
        tick();

        frame(3'b001, 24'h000000, 6, 6'h05);
        result("m1_ok", 1'b1, 1'b0, 1'b0, 6'h05, 1'b1);
        frame(3'b010, 24'h000000, 4, 6'h0C);
        result("m2_ok", 1'b1, 1'b0, 1'b0, 6'h0C, 1'b1);
        frame(3'b010, 24'h000000, 4, 6'h0D);
        result("m2_err", 1'b0, 1'b1, 1'b0, 6'h0C, 1'b1);
        frame(3'b010, 24'h000000, 4, 6'h3C);
        result("m2_hi_ignored", 1'b1, 1'b0, 1'b0, 6'h0C, 1'b1);
        frame(3'b011, 24'h000000, 3, 6'h09);
        result("m3_ok", 1'b1, 1'b0, 1'b0, 6'h09, 1'b1);
        start(3'b011);
        nib(4'h0);
        nib(4'h0);
        send_crc(6'h09);
        result("m3_short", 1'b0, 1'b0, 1'b1, 6'h00, 1'b0);
        frame(3'b100, 24'h000000, 4, 6'h0C);
        result("m4_ok", 1'b1, 1'b0, 1'b0, 6'h0C, 1'b1);

        frame(3'b101, 24'h000000, 6, 6'h26);
        result("m5_zero", 1'b1, 1'b0, 1'b0, 6'h26, 1'b1);
        w_ref = m_crc6(24'hA371C5);
        frame(3'b101, 24'hA371C5, 6, w_ref);
        result("m5_ok", 1'b1, 1'b0, 1'b0, w_ref, 1'b1);
        frame(3'b101, 24'hA371C5, 6, w_ref ^ 6'h01);
        result("m5_err", 1'b0, 1'b1, 1'b0, w_ref, 1'b1);

        start(3'b001);
        nib(4'hF);
        nib(4'hF);
        nib(4'hF);
        frame(3'b001, 24'h000000, 6, 6'h05);
        result("abort", 1'b1, 1'b0, 1'b0, 6'h05, 1'b1);

        start(3'b001);
        nib(4'h0);
        nibble_valid_i = 1'b1;
        crc_valid_i = 1'b1;
        tick();
        nibble_valid_i = 1'b0;
        crc_valid_i = 1'b0;
        result("both_valid", 1'b0, 1'b0, 1'b1, 6'h00, 1'b0);

        start(3'b011);
        nib(4'h0);
        nib(4'h0);
        nib(4'h0);
        tick();
        tick();
        nib(4'h0);
        result("nib_in_wait", 1'b0, 1'b0, 1'b1, 6'h00, 1'b0);

        frame(3'b010, 24'h000000, 4, 6'h0C);
        mode_i = 3'b001;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        chk("start_in_result.done", {4'b0, crc_check_done_o, crc_ok_o}, 6'b000011);
        for (int i = 0; i < 6; i++) nib(4'h0);
        tick();
        tick();
        send_crc(6'h05);
        result("after_restart", 1'b1, 1'b0, 1'b0, 6'h05, 1'b1);

        start(3'b111);
        result("m7_invalid", 1'b0, 1'b0, 1'b1, 6'h00, 1'b0);

        frame(3'b001, 24'h000000, 6, 6'h05);
        tick();
        reset_n_rx = 1'b0;
        #1;
        chk("async_rst.flags", {2'b0, crc_check_done_o, crc_ok_o, crc_err_o, frame_err_o}, 6'd0);
        chk("async_rst.calc", crc_calc_o, 6'd0);
        tick();
        reset_n_rx = 1'b1;
        tick();

        start(3'b001);
        nib(4'h0);
        nib(4'h0);
        reset_n_rx = 1'b0;
        tick();
        reset_n_rx = 1'b1;
        for (int i = 0; i < 4; i++) nib(4'h0);
        tick();
        tick();
        send_crc(6'h05);
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst.no_done", 6'(crc_check_done_o), 6'd0);
            tick();
        end
        frame(3'b001, 24'h000000, 6, 6'h05);
        result("recover", 1'b1, 1'b0, 1'b0, 6'h05, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
